// File: rtl/pipelined_cla_addsub.sv
// Skewed-pipeline carry-look-ahead adder/subtractor: one WIDTH/STAGES slice per stage,
// slice carries registered forward, valid/ready handshake with per-stage bubble collapse.
module pipelined_cla_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int GROUP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / GROUP;

   // Returns {carry_out, sum} of one slice; group G/P terms chain the group carries.
   function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          c0);
      logic [SW-1:0] g, p, s;
      logic [NG:0]   cg;
      logic          gg, gp, c;
      g     = x & y;
      p     = x ^ y;
      s     = '0;
      cg    = '0;
      cg[0] = c0;
      for (int j = 0; j < NG; j++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
            gp = gp & p[j*GROUP+i];
         end
         cg[j+1] = gg | (gp & cg[j]);
         c = cg[j];
         for (int i = 0; i < GROUP; i++) begin
            s[j*GROUP+i] = p[j*GROUP+i] ^ c;
            c = g[j*GROUP+i] | (p[j*GROUP+i] & c);
         end
      end
      return {cg[NG], s};
   endfunction

   logic ovf_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // RW: bits still to be summed when a beat enters this stage (this slice and above)
      localparam int RW = WIDTH - k*SW;

      logic                vld_q, rdy, up_vld, dn_rdy, c_in, c_q, ld;
      logic [RW-1:0]       src_a, src_b;
      logic [SW:0]         res;
      logic [(k+1)*SW-1:0] s_d, s_q;

      if (k == 0) begin : g_head
         assign up_vld = in_valid;
         assign src_a  = a;
         assign src_b  = b ^ {WIDTH{sub}};
         assign c_in   = sub | cin;
         assign s_d    = res[SW-1:0];
      end else begin : g_body
         assign up_vld = g_stage[k-1].vld_q;
         assign src_a  = g_stage[k-1].g_pend.pa_q;
         assign src_b  = g_stage[k-1].g_pend.pb_q;
         assign c_in   = g_stage[k-1].c_q;
         assign s_d    = {res[SW-1:0], g_stage[k-1].s_q};
      end

      if (k == STAGES-1) begin : g_dn_out
         assign dn_rdy = out_ready;
      end else begin : g_dn_stage
         assign dn_rdy = g_stage[k+1].rdy;
      end

      assign rdy = !vld_q || dn_rdy;
      assign ld  = rdy && up_vld;
      assign res = cla_slice(src_a[SW-1:0], src_b[SW-1:0], c_in);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            s_q   <= '0;
            c_q   <= 1'b0;
         end else begin
            if (rdy) vld_q <= up_vld;
            if (ld) begin
               s_q <= s_d;
               c_q <= res[SW];
            end
         end
      end

      if (k < STAGES-1) begin : g_pend
         logic [RW-SW-1:0] pa_q, pb_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pa_q <= '0;
               pb_q <= '0;
            end else if (ld) begin
               pa_q <= src_a[RW-1:SW];
               pb_q <= src_b[RW-1:SW];
            end
         end
      end else begin : g_last
         // Operand MSBs are only visible here, so overflow is resolved while loading the last stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ovf_q <= 1'b0;
            else if (ld) ovf_q <= (src_a[RW-1] == src_b[RW-1]) && (res[SW-1] != src_a[RW-1]);
         end
      end
   end

   assign in_ready  = g_stage[0].rdy;
   assign out_valid = g_stage[STAGES-1].vld_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor; successor to the team's fixed 32-bit combinational CLA.
- The operand width is split into STAGES equal slices. Each slice is summed by a GROUP-bit look-ahead tree, and the slice carry is registered into the next stage (skewed pipeline).
- Valid/ready streaming on both sides with per-stage bubble collapse.
- Sits between operand-producing datapath logic and result consumers in the ALU path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline slices and register stages; latency in cycles; 1..8.
- GROUP, 4, CLA group size within a slice; (WIDTH/STAGES) must be divisible by GROUP.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B+cin; 1: A+~B+1 (cin ignored).
- cin  input  1  carry in, add mode only.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync deassert by the system): all stage valid bits = 0, so out_valid = 0. sum, cout and ovf = 0. Data registers need not reset beyond the outputs.
- Transfer occurs on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
- Stage k (0..STAGES-1) holds valid_k, the computed low slices, the pending high slices of A and B', and the registered slice carry.
- ready_last = out_ready.
- ready_k = !valid_k || ready_{k+1}, where stage STAGES-1 uses ready_last.
- in_ready = ready_0, which is combinational from out_ready through the stage chain.
- A stage loads when its upstream is valid and it is ready. It holds its contents while stalled, and drops to invalid when drained with no new input.
- Stage k computes slice k with a GROUP-level generate/propagate tree, using the carry registered in stage k-1 (stage 0 uses the effective carry in).
- Effective B is b ^ {WIDTH{sub}}; effective carry in is sub ? 1 : cin. Both are captured at acceptance.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (stage registers) when unstalled. Throughput is 1 beat/cycle.
- Bubbles collapse: a stalled output does not block upstream stages that are empty.
- cout is the MSB carry out. ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Outputs are stable while out_valid && !out_ready (no data change, no drop).
- Reset mid-operation discards all in-flight beats immediately; out_valid falls asynchronously.
- Simultaneous accept and emit in one cycle with a full pipe is supported with no loss or duplication.
- STAGES=1 degenerates to a single registered CLA with latency 1.

Test Plan:
1. Reset release, idle -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
2. Add, WIDTH=32/STAGES=2: a=0xA0A0FFFF, b=0xA0BFFFE0, cin=0 -> 2 cycles later sum=0x4160FFDF, cout=1, ovf=1.
3. Subtract: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
4. Carry ripple across slice boundary: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, ovf=0. Also a=0x0000FFFF, b=1 -> sum=0x00010000.
5. Backpressure: stream 6 beats back-to-back while out_ready is held low for 4 cycles mid-stream -> in_ready falls once the pipe is full. Held result is stable. All 6 results emerge in order with no loss or duplication. Throughput returns to 1/cycle once out_ready rises.
6. Reset asserted with 2 beats in flight -> out_valid=0 immediately. After release, a new beat a=1, b=2 yields sum=3 with no stale results emitted.
